kanagawa_fifo_drain: RTL and testbench

//   Read-side adapter for the Kanagawa FIFO interface (show-ahead: q valid while !empty,

---
 rtl/kanagawa_fifo_drain.sv | 92 +++++++++
 tb/tb_kanagawa_fifo_drain.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/kanagawa_fifo_drain.sv
// Show-ahead FIFO read adapter driving a registered valid/ready stream.
// Two-entry skid buffer; rdreq never depends on out_ready.
module kanagawa_fifo_drain #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_q,
  output logic             fifo_rdreq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    CNT0 = 2'd0,
    CNT1 = 2'd1,
    CNT2 = 2'd2
  } cnt_e;

  cnt_e             cnt_q;
  cnt_e             cnt_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] tail_q;
  logic [WIDTH-1:0] tail_d;
  logic             push;
  logic             pop;

  // rst gate keeps the pop request quiet while the buffer is held cleared
  assign push       = !rst && !fifo_empty && (cnt_q != CNT2);
  assign pop        = out_valid && out_ready;
  assign fifo_rdreq = push;
  assign out_valid  = (cnt_q != CNT0);
  assign out_data   = head_q;
  assign occupancy  = cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case (cnt_q)
      CNT0: begin
        if (push) begin
          cnt_d  = CNT1;
          head_d = fifo_q;
        end
      end
      CNT1: begin
        unique case (1'b1)
          push && !pop: begin
            cnt_d  = CNT2;
            tail_d = fifo_q;
          end
          pop && !push: begin
            cnt_d = CNT0;
          end
          push && pop: begin
            head_d = fifo_q;
          end
          default: begin
            cnt_d = CNT1;
          end
        endcase
      end
      CNT2: begin
        if (pop) begin
          cnt_d  = CNT1;
          head_d = tail_q;
        end
      end
      default: begin
        cnt_d = CNT0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q  <= CNT0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: tb/tb_kanagawa_fifo_drain.sv
// Randomised bench for kanagawa_fifo_drain against a queue model
// of the upstream FIFO and the words held inside the adapter.
module tb_kanagawa_fifo_drain;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_q = '0;
  logic         fifo_rdreq;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  kanagawa_fifo_drain #(.WIDTH(W)) dut (
    .clock      (clock),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] src[$];
  logic [W-1:0] mq[$];
  logic [W-1:0] dlog[$];

  logic         t_rd;
  logic [1:0]   t_occ;
  logic [W-1:0] t_data;
  logic         t_del_v;
  logic [W-1:0] t_del;

  task automatic chk(input string n, input logic [W-1:0] a,
                     input logic [W-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance model.
  task automatic tick(input bit gate, input bit rdy);
    logic exp_rd;
    fifo_empty = gate || (src.size() == 0);
    fifo_q     = (src.size() != 0) ? src[0] : '0;
    out_ready  = rdy;
    @(negedge clock);
    t_rd   = fifo_rdreq;
    t_occ  = occupancy;
    t_data = out_data;
    if (rst) mq.delete();
    exp_rd = !rst && !fifo_empty && (mq.size() < 2);
    chk("rdreq", {31'd0, fifo_rdreq}, {31'd0, exp_rd});
    chk("valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk("occ", {30'd0, occupancy}, W'(mq.size()));
    if (mq.size() != 0) chk("data", out_data, mq[0]);
    if (fifo_empty && fifo_rdreq) chk("rd_while_empty", 32'd1, 32'd0);
    t_del_v = 1'b0;
    if (!rst) begin
      if (mq.size() != 0 && rdy) begin
        t_del   = mq.pop_front();
        t_del_v = 1'b1;
        dlog.push_back(t_del);
      end
      if (exp_rd) mq.push_back(src.pop_front());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    chk("rst_data", out_data, '0);
    tick(1'b0, 1'b0);
    rst = 1'b0;
    dlog.delete();
  endtask

  task automatic load(input int first, input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(W'(first + i));
  endtask

  initial begin
    int seq;
    int base;
    // reset with data pending upstream
    load(1, 8);
    do_reset();
    // streaming: first rdreq right after release, words on 8 cycles
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1);
      if (i == 0) chk("first_rd", {31'd0, t_rd}, 32'd1);
      if (i >= 1 && i <= 8)
        chk("stream", t_del_v ? t_del : 32'hdead_beef, W'(i));
    end
    chk("stream_cnt", W'(dlog.size()), 32'd8);

    // backpressure
    load(1, 5);
    do_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("bp_occ1", {30'd0, t_occ}, 32'd1);
    tick(1'b0, 1'b0);
    chk("bp_occ2", {30'd0, t_occ}, 32'd2);
    chk("bp_rd", {31'd0, t_rd}, 32'd0);
    chk("bp_hold", t_data, 32'd1);
    tick(1'b0, 1'b1);
    chk("bp_d1", t_del_v ? t_del : 32'hdead_beef, 32'd1);
    tick(1'b0, 1'b1);
    chk("bp_d2", t_del_v ? t_del : 32'hdead_beef, 32'd2);
    tick(1'b0, 1'b1);
    chk("bp_d3", t_del_v ? t_del : 32'hdead_beef, 32'd3);

    // sparse upstream
    load(1, 16);
    do_reset();
    for (int i = 0; i < 40; i++) tick(1'(i % 2), 1'b1);
    chk("sparse_cnt", W'(dlog.size()), 32'd16);
    for (int i = 0; i < dlog.size(); i++)
      chk("sparse_ord", dlog[i], W'(i + 1));

    // asynchronous reset with two buffered words
    load(1, 10);
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    chk("mr_occ", {30'd0, occupancy}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_occ0", {30'd0, occupancy}, 32'd0);
    mq.delete();
    tick(1'b0, 1'b1);
    rst = 1'b0;
    dlog.delete();
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
    chk("mr_cnt", W'(dlog.size()), 32'd8);
    for (int i = 0; i < dlog.size(); i++)
      chk("mr_ord", dlog[i], W'(i + 3));

    // random traffic
    src.delete();
    dlog.delete();
    seq  = 0;
    base = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) != 0 && src.size() < 8) begin
        src.push_back(W'(base + seq));
        seq++;
      end
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b1);
    chk("rnd_cnt", W'(dlog.size()), W'(seq));
    for (int i = 0; i < dlog.size(); i++)
      if (dlog[i] !== W'(base + i)) chk("rnd_ord", dlog[i], W'(base + i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
